key_action_gen: RTL and testbench
=================================

Name: key_action_gen

Overview:
- Consumes the two-slot held-key state from the PS/2 keyboard decoder and produces single-cycle game-action pulses for the Tetris game-logic FSM.
- Inputs are asynchronous to clk because they are generated from PS2_CLK. The block synchronises and qualifies them first.
- Movement keys get delayed auto-shift: one immediate pulse, then repeats after DAS_CYC, then one every ARR_CYC.
- Rotation, hard-drop and start keys give one pulse per press.

Parameters:
- DAS_CYC, 8000000, cycles from the first move pulse to the first repeat (160 ms at 50 MHz).
- ARR_CYC, 2500000, cycles between successive repeats.
- CNT_W, 24, repeat-counter width. Must hold max(DAS_CYC, ARR_CYC).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pause  in  1  game paused; suppresses all pulses except start_p
- key1_on  in  1  slot-1 key held (async)
- key1_code  in  8  slot-1 scan code; 8'hF0 when empty (async)
- key2_on  in  1  slot-2 key held (async)
- key2_code  in  8  slot-2 scan code (async)
- mv_left  out  1  move-left pulse
- mv_right  out  1  move-right pulse
- mv_down  out  1  soft-drop pulse
- hard_drop  out  1  hard-drop pulse
- rot_cw  out  1  rotate-clockwise pulse
- rot_ccw  out  1  rotate-counter-clockwise pulse
- start_p  out  1  start/enter pulse

Behaviour:
- Reset: all outputs 0, key1 FSM in IDLE, counter 0, accepted snapshots = {on=0, code=F0}. Reset mid-hold drops state. No pulse follows until the key is released and pressed again after reset deasserts.
- Input qualification, per slot: the 9-bit {on, code} passes through 2 sync flops (s1, s2), then s3. The accepted snapshot acc loads s2 only when s2==s3, which rejects torn code/on samples.
- Fixed latency: a stable input change sampled at edge N gives an output pulse high in cycle N+4.
- Press event: acc.on goes 0->1, or acc.code changes while acc.on=1. The second case counts as release plus new press. Release event: acc.on goes 1->0.
- Code map:
  - 6B -> mv_left, 74 -> mv_right, 72 -> mv_down (all repeatable)
  - 75 -> hard_drop, 5A -> start_p (single pulse)
  - 12 or 22 -> rot_cw, 1A -> rot_ccw
  - Any other code: ignored, FSM stays IDLE.
- Key1 FSM:
  - IDLE: on a press of a mapped key, emit one pulse. If the key is repeatable, load cnt=DAS_CYC-1 and go to DAS; otherwise go to LATCHED.
  - DAS: cnt decrements each cycle. At cnt==0, emit a pulse, load ARR_CYC-1, go to REPEAT.
  - REPEAT: at cnt==0, emit a pulse and reload ARR_CYC-1.
  - LATCHED: wait for release.
  - Any state: a release goes to IDLE with no pulse, even if cnt==0 in the same cycle.
- Key2: edge-detect only, one pulse per press event. No FSM.
- Timing: pulses at P, P+DAS_CYC, then P+DAS_CYC+k*ARR_CYC.
- Simultaneous events: key1 and key2 pulses may assert in the same cycle. Outputs are independent.
- pause=1: movement, drop and rotate pulses forced to 0 and the key1 FSM forced to IDLE. start_p is unaffected, so Enter can unpause.
  - A key still held when pause falls produces no pulse until it is re-pressed.
- All outputs are registered. Every pulse is exactly 1 cycle wide.

Optional Feature:
- Macro KEYACT_AUTOREPEAT_EN.
- Defined: DAS/REPEAT behaviour as above.
- Undefined: no DAS or REPEAT states and no counter. Every mapped key gives exactly one pulse per press, then LATCHED until release.
- Latency is identical in both builds.

Decomposition:
- Package keyact_pkg holds:
  - scan-code localparams: KC_UP 75, KC_DOWN 72, KC_LEFT 6B, KC_RIGHT 74, KC_ROT 12, KC_LROT 1A, KC_RROT 22, KC_ENTER 5A, KC_NONE F0
  - the key1 state enum {IDLE, LATCHED, DAS, REPEAT}.
- Sub-module key_sync, 9-bit, instantiated twice: the 2-flop synchroniser, the stability compare, and the acc register.

Test Plan (DAS_CYC=10, ARR_CYC=4, AUTOREPEAT_EN defined):
- key1={1,6B} at cycle 0, released at cycle 28 -> mv_left high in cycles 4, 14, 18, 22, 26, 30 only.
- key1={1,75} held 50 cycles -> hard_drop high in cycle 4 only. No other output toggles.
- key1={1,72} and key2={1,1A} at cycle 0 -> mv_down and rot_ccw both high in cycle 4.
- key1 code glitch: code=6B with on=0 for 1 cycle, then on=1 -> no pulse until the stable sample. mv_left appears exactly 4 cycles after the stable {1,6B}.
- pause=1 while {1,74} held, pause drops at cycle 40 -> no mv_right. Release then re-press at cycle 60 -> mv_right at cycle 64. key1={1,5A} during pause -> start_p pulses.
- rst asserted at cycle 12 during a held 6B, deasserted at cycle 15 -> outputs 0 from cycle 13. No pulse while held. Re-press gives a pulse at +4.

Source files
------------

// File: rtl/keyact_pkg.sv
// ----------------------------------------------------------------------------
// keyact_pkg
// Shared definitions for the keyboard-to-game-action block:
//   - PS/2 set-2 scan codes of the keys the game reacts to
//   - key1 state enum, held-key snapshot struct, action-pulse struct
//   - decode helpers mapping a scan code to its action / repeat class
// ----------------------------------------------------------------------------
package keyact_pkg;

    localparam logic [7:0] KC_UP    = 8'h75;
    localparam logic [7:0] KC_DOWN  = 8'h72;
    localparam logic [7:0] KC_LEFT  = 8'h6B;
    localparam logic [7:0] KC_RIGHT = 8'h74;
    localparam logic [7:0] KC_ROT   = 8'h12;
    localparam logic [7:0] KC_LROT  = 8'h1A;
    localparam logic [7:0] KC_RROT  = 8'h22;
    localparam logic [7:0] KC_ENTER = 8'h5A;
    localparam logic [7:0] KC_NONE  = 8'hF0;

    // Cycles after reset during which snapshot edges are ignored: covers the
    // synchroniser/acceptance pipeline so a key held through reset cannot
    // masquerade as a fresh press.
    localparam logic [2:0] FLUSH_CYC = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        LATCHED,
        DAS,
        REPEAT
    } key1_state_e;

    typedef struct packed {
        logic       on;
        logic [7:0] code;
    } key_snap_t;

    localparam key_snap_t SNAP_EMPTY = '{on: 1'b0, code: KC_NONE};

    typedef struct packed {
        logic mv_left;
        logic mv_right;
        logic mv_down;
        logic hard_drop;
        logic rot_cw;
        logic rot_ccw;
        logic start;
    } act_t;

    localparam act_t ACT_NONE       = '0;
    localparam act_t ACT_START_ONLY = '{start: 1'b1, default: 1'b0};

    function automatic act_t decode_key(input logic [7:0] code);
        act_t a;
        a = ACT_NONE;
        case (code)
            KC_LEFT:          a.mv_left   = 1'b1;
            KC_RIGHT:         a.mv_right  = 1'b1;
            KC_DOWN:          a.mv_down   = 1'b1;
            KC_UP:            a.hard_drop = 1'b1;
            KC_ROT, KC_RROT:  a.rot_cw    = 1'b1;
            KC_LROT:          a.rot_ccw   = 1'b1;
            KC_ENTER:         a.start     = 1'b1;
            default:          a = ACT_NONE;
        endcase
        return a;
    endfunction

    function automatic logic is_repeatable(input logic [7:0] code);
        return (code == KC_LEFT) || (code == KC_RIGHT) || (code == KC_DOWN);
    endfunction

endpackage

// File: rtl/key_sync.sv
// ----------------------------------------------------------------------------
// key_sync
// Brings a multi-bit asynchronous key snapshot into the clk domain. Two flops
// synchronise, a third holds the previous synchronised word, and the accepted
// snapshot only updates when two consecutive synchronised words agree, so a
// word caught mid-change (torn code/on bits) never reaches the decoder.
//
// Ports:
//   clk    in  1   system clock
//   rst    in  1   synchronous active-high reset
//   d_i    in  W   asynchronous snapshot
//   acc_o  out W   accepted (stable) snapshot
// ----------------------------------------------------------------------------
module key_sync #(
    parameter int           W       = 9,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] s1_q, s2_q, s3_q;
    logic [W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = (s2_q == s3_q) ? s2_q : acc_q;
    end

    // NOTE: non-blocking assignments let every flop sample the pre-edge value
    // of its neighbour; blocking here would collapse the chain into one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= RST_VAL;
            s2_q  <= RST_VAL;
            s3_q  <= RST_VAL;
            acc_q <= RST_VAL;
        end else begin
            s1_q  <= d_i;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/key_action_gen.sv
// ----------------------------------------------------------------------------
// key_action_gen
// Turns the two-slot held-key state of the PS/2 decoder into single-cycle
// game-action pulses. Slot 1 drives a small FSM (one pulse per press, plus
// delayed auto-shift for movement keys); slot 2 is edge-detect only.
// Latency from a stable input change to its pulse is 4 clock edges.
//
// Build option: define KEYACT_AUTOREPEAT_EN to enable DAS/ARR auto-repeat of
// the movement keys; without it every mapped key pulses once per press.
//
// Ports:
//   clk        in  1  system clock
//   rst        in  1  synchronous active-high reset
//   pause      in  1  suppresses all pulses except start_p
//   key1_on    in  1  slot-1 key held (async)
//   key1_code  in  8  slot-1 scan code, F0 when empty (async)
//   key2_on    in  1  slot-2 key held (async)
//   key2_code  in  8  slot-2 scan code (async)
//   mv_left, mv_right, mv_down, hard_drop, rot_cw, rot_ccw, start_p
//              out 1  registered one-cycle action pulses
// ----------------------------------------------------------------------------
module key_action_gen
    import keyact_pkg::*;
#(
    parameter int DAS_CYC = 8000000,
    parameter int ARR_CYC = 2500000,
    parameter int CNT_W   = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic       key1_on,
    input  logic [7:0] key1_code,
    input  logic       key2_on,
    input  logic [7:0] key2_code,
    output logic       mv_left,
    output logic       mv_right,
    output logic       mv_down,
    output logic       hard_drop,
    output logic       rot_cw,
    output logic       rot_ccw,
    output logic       start_p
);

    if (CNT_W < 1 || DAS_CYC < 1 || ARR_CYC < 1 ||
        longint'(DAS_CYC) > (longint'(1) << CNT_W) ||
        longint'(ARR_CYC) > (longint'(1) << CNT_W)) begin : g_bad_cfg
        $error("key_action_gen: DAS_CYC/ARR_CYC must be >= 1 and fit in CNT_W bits");
    end

    key_snap_t   acc1, acc2;
    key_snap_t   prev1_q, prev2_q;
    logic [2:0]  flush_q;
    logic        settled;
    logic        press1, rel1, press2;
    key1_state_e state_q, state_d;
    act_t        act1, act2, act_d, act_q;

    key_sync #(.W(9), .RST_VAL(SNAP_EMPTY)) u_sync1 (
        .clk   (clk),
        .rst   (rst),
        .d_i   ({key1_on, key1_code}),
        .acc_o (acc1)
    );

    key_sync #(.W(9), .RST_VAL(SNAP_EMPTY)) u_sync2 (
        .clk   (clk),
        .rst   (rst),
        .d_i   ({key2_on, key2_code}),
        .acc_o (acc2)
    );

    // A code change while held counts as a press of the new key.
    assign settled = (flush_q == '0);
    assign press1  = settled && acc1.on && (!prev1_q.on || acc1.code != prev1_q.code);
    assign rel1    = settled && prev1_q.on && !acc1.on;
    assign press2  = settled && acc2.on && (!prev2_q.on || acc2.code != prev2_q.code);

`ifdef KEYACT_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_CYC - 1);
    localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        act1    = ACT_NONE;
`ifdef KEYACT_AUTOREPEAT_EN
        cnt_d   = cnt_q;
`endif
        if (rel1) begin
            // Release wins over a repeat that is due in the same cycle.
            state_d = IDLE;
        end else if (press1) begin
            act1 = decode_key(acc1.code);
            if (act1 == ACT_NONE) begin
                state_d = IDLE;
`ifdef KEYACT_AUTOREPEAT_EN
            end else if (is_repeatable(acc1.code)) begin
                state_d = DAS;
                cnt_d   = DAS_LOAD;
`endif
            end else begin
                state_d = LATCHED;
            end
`ifdef KEYACT_AUTOREPEAT_EN
        end else if (state_q == DAS || state_q == REPEAT) begin
            if (cnt_q == '0) begin
                act1    = decode_key(acc1.code);
                cnt_d   = ARR_LOAD;
                state_d = REPEAT;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
`endif
        end
        if (pause) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        act2  = press2 ? decode_key(acc2.code) : ACT_NONE;
        act_d = act1 | act2;
        // Start stays live while paused so Enter can resume the game.
        if (pause) begin
            act_d = act_d & ACT_START_ONLY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            act_q   <= ACT_NONE;
            prev1_q <= SNAP_EMPTY;
            prev2_q <= SNAP_EMPTY;
            flush_q <= FLUSH_CYC;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            prev1_q <= acc1;
            prev2_q <= acc2;
            if (flush_q != '0) begin
                flush_q <= flush_q - 3'd1;
            end
        end
    end

`ifdef KEYACT_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign mv_left   = act_q.mv_left;
    assign mv_right  = act_q.mv_right;
    assign mv_down   = act_q.mv_down;
    assign hard_drop = act_q.hard_drop;
    assign rot_cw    = act_q.rot_cw;
    assign rot_ccw   = act_q.rot_ccw;
    assign start_p   = act_q.start;

endmodule

// File: tb/tb_key_action_gen.sv
// ----------------------------------------------------------------------------
// tb_key_action_gen
// Self-checking bench for key_action_gen (DAS_CYC=10, ARR_CYC=4). A reference
// model derives expected pulses from the key rules: inputs must be seen on two
// consecutive edges to count, events surface 4 edges after the first stable
// sample, and repeat pulses fall at P, P+DAS, P+DAS+k*ARR while held.
// Follows KEYACT_AUTOREPEAT_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_key_action_gen;

    localparam int TB_DAS = 10;
    localparam int TB_ARR = 4;
    localparam int MAXC   = 4096;
`ifdef KEYACT_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    // bit order of obs: {mv_left, mv_right, mv_down, hard_drop, rot_cw, rot_ccw, start_p}
    localparam logic [6:0] B_LEFT  = 7'b1000000;
    localparam logic [6:0] B_RIGHT = 7'b0100000;
    localparam logic [6:0] B_DOWN  = 7'b0010000;
    localparam logic [6:0] B_HARD  = 7'b0001000;
    localparam logic [6:0] B_CW    = 7'b0000100;
    localparam logic [6:0] B_CCW   = 7'b0000010;
    localparam logic [6:0] B_START = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic       key1_on = 1'b0;
    logic [7:0] key1_code = 8'hF0;
    logic       key2_on = 1'b0;
    logic [7:0] key2_code = 8'hF0;
    logic       mv_left, mv_right, mv_down, hard_drop, rot_cw, rot_ccw, start_p;
    logic [6:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    assign obs = {mv_left, mv_right, mv_down, hard_drop, rot_cw, rot_ccw, start_p};

    always #5 clk = ~clk;

    key_action_gen #(
        .DAS_CYC (TB_DAS),
        .ARR_CYC (TB_ARR),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pause     (pause),
        .key1_on   (key1_on),
        .key1_code (key1_code),
        .key2_on   (key2_on),
        .key2_code (key2_code),
        .mv_left   (mv_left),
        .mv_right  (mv_right),
        .mv_down   (mv_down),
        .hard_drop (hard_drop),
        .rot_cw    (rot_cw),
        .rot_ccw   (rot_ccw),
        .start_p   (start_p)
    );

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [8:0] f1_h [MAXC];   // filtered (stable) key-1 state per edge
    logic [8:0] f2_h [MAXC];
    logic [8:0] last_in1 = 9'h0F0;
    logic [8:0] last_in2 = 9'h0F0;
    int         cyc = -1;
    int         mask = 0;
    bit         active = 1'b0;
    int         t_press = 0;
    logic [7:0] held_code = 8'hF0;
    logic [6:0] exp_v = '0;

    function automatic logic [6:0] action_of(input logic [7:0] code);
        case (code)
            8'h6B:        return B_LEFT;
            8'h74:        return B_RIGHT;
            8'h72:        return B_DOWN;
            8'h75:        return B_HARD;
            8'h12, 8'h22: return B_CW;
            8'h1A:        return B_CCW;
            8'h5A:        return B_START;
            default:      return 7'b0;
        endcase
    endfunction

    function automatic bit repeats(input logic [7:0] code);
        return (code == 8'h6B) || (code == 8'h74) || (code == 8'h72);
    endfunction

    function automatic logic [8:0] hist(input int which, input int idx);
        if (idx < 0) return 9'h0F0;
        return (which == 1) ? f1_h[idx] : f2_h[idx];
    endfunction

    // Advance one clock edge, update the model for that edge, then settle.
    task automatic tick();
        logic [8:0] i1, i2, a1, b1, a2, b2;
        logic [6:0] e1, e2;
        bit         pr1, rl1, pr2;
        @(posedge clk);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL model_overflow cycle=%0d limit=%0d", cyc, MAXC);
            $fatal(1);
        end
        i1 = rst ? 9'h0F0 : {key1_on, key1_code};
        i2 = rst ? 9'h0F0 : {key2_on, key2_code};
        f1_h[cyc] = rst ? 9'h0F0 : ((i1 == last_in1) ? i1 : hist(1, cyc - 1));
        f2_h[cyc] = rst ? 9'h0F0 : ((i2 == last_in2) ? i2 : hist(2, cyc - 1));
        last_in1 = i1;
        last_in2 = i2;
        e1 = '0;
        e2 = '0;
        if (rst) begin
            mask   = 5;
            active = 1'b0;
            exp_v  = '0;
        end else begin
            a1  = hist(1, cyc - 3);
            b1  = hist(1, cyc - 4);
            a2  = hist(2, cyc - 3);
            b2  = hist(2, cyc - 4);
            pr1 = (mask == 0) && a1[8] && (!b1[8] || a1[7:0] != b1[7:0]);
            rl1 = (mask == 0) && !a1[8] && b1[8];
            pr2 = (mask == 0) && a2[8] && (!b2[8] || a2[7:0] != b2[7:0]);
            if (mask != 0) mask--;
            if (rl1) begin
                active = 1'b0;
            end else if (pr1) begin
                e1        = action_of(a1[7:0]);
                active    = AUTOREP && repeats(a1[7:0]);
                t_press   = cyc;
                held_code = a1[7:0];
            end else if (active && (cyc - t_press) >= TB_DAS &&
                         ((cyc - t_press - TB_DAS) % TB_ARR) == 0) begin
                e1 = action_of(held_code);
            end
            if (pr2) e2 = action_of(a2[7:0]);
            if (pause) begin
                active = 1'b0;
                exp_v  = (e1 | e2) & B_START;
            end else begin
                exp_v = e1 | e2;
            end
        end
        #1;
    endtask

    task automatic set_keys(input logic on1, input logic [7:0] c1,
                            input logic on2, input logic [7:0] c2);
        key1_on = on1; key1_code = c1;
        key2_on = on2; key2_code = c2;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_keys(1'b0, 8'hF0, 1'b0, 8'hF0);
        for (int t = 0; t < 4; t++) begin
            tick();
            n_tests++;
            if (obs !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_outputs t=%0d got=%b want=%b", t, obs, 7'b0);
            end
        end
        rst = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_idle t=%0d got=%b want=%b", t, obs, exp_v);
            end
        end
    endtask

    task automatic test_das_repeat();
        logic [63:0] seen, want;
        seen = '0;
        for (int t = 0; t < 44; t++) begin
            if (t < 28) set_keys(1'b1, 8'h6B, 1'b0, 8'hF0);
            else        set_keys(1'b0, 8'hF0, 1'b0, 8'hF0);
            tick();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL das_model t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (mv_left === 1'b1) seen[t] = 1'b1;
        end
        want = '0;
        want[4] = 1'b1;
        if (AUTOREP) begin
            want[14] = 1'b1; want[18] = 1'b1; want[22] = 1'b1;
            want[26] = 1'b1; want[30] = 1'b1;
        end
        n_tests++;
        if (seen !== want) begin
            n_fail++;
            $display("FAIL das_pulse_cycles got=%h want=%h", seen, want);
        end
    endtask

    task automatic test_single_pulse();
        logic [63:0] seen;
        int          others;
        seen   = '0;
        others = 0;
        for (int t = 0; t < 60; t++) begin
            if (t < 50) set_keys(1'b1, 8'h75, 1'b0, 8'hF0);
            else        set_keys(1'b0, 8'hF0, 1'b0, 8'hF0);
            tick();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL single_model t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (hard_drop === 1'b1) seen[t] = 1'b1;
            if ((obs & ~B_HARD) !== 7'b0) others++;
        end
        n_tests++;
        if (seen !== (64'd1 << 4)) begin
            n_fail++;
            $display("FAIL hard_drop_cycles got=%h want=%h", seen, 64'd1 << 4);
        end
        n_tests++;
        if (others !== 0) begin
            n_fail++;
            $display("FAIL single_other_outputs got=%0d want=0", others);
        end
    endtask

    task automatic test_simultaneous();
        for (int t = 0; t < 16; t++) begin
            if (t < 8) set_keys(1'b1, 8'h72, 1'b1, 8'h1A);
            else       set_keys(1'b0, 8'hF0, 1'b0, 8'hF0);
            tick();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL simul_model t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (t == 4) begin
                n_tests++;
                if (obs !== (B_DOWN | B_CCW)) begin
                    n_fail++;
                    $display("FAIL simul_both t=4 got=%b want=%b", obs, B_DOWN | B_CCW);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int first_left, spike_right;
        first_left  = -1;
        spike_right = 0;
        for (int t = 0; t < 32; t++) begin
            if (t == 0)      set_keys(1'b0, 8'h6B, 1'b0, 8'hF0);
            else if (t < 10) set_keys(1'b1, 8'h6B, 1'b0, 8'hF0);
            else if (t == 20) set_keys(1'b1, 8'h74, 1'b0, 8'hF0);
            else             set_keys(1'b0, 8'hF0, 1'b0, 8'hF0);
            tick();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL glitch_model t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (mv_left === 1'b1 && first_left < 0) first_left = t;
            if (mv_right === 1'b1) spike_right++;
        end
        n_tests++;
        if (first_left !== 5) begin
            n_fail++;
            $display("FAIL glitch_first_left got=%0d want=5", first_left);
        end
        n_tests++;
        if (spike_right !== 0) begin
            n_fail++;
            $display("FAIL glitch_spike_right got=%0d want=0", spike_right);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] seen_l, seen_r;
        seen_l = '0;
        seen_r = '0;
        for (int t = 0; t < 20; t++) begin
            if (t < 6)       set_keys(1'b1, 8'h6B, 1'b0, 8'hF0);
            else if (t < 12) set_keys(1'b1, 8'h74, 1'b0, 8'hF0);
            else             set_keys(1'b0, 8'hF0, 1'b0, 8'hF0);
            tick();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_model t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (mv_left === 1'b1)  seen_l[t] = 1'b1;
            if (mv_right === 1'b1) seen_r[t] = 1'b1;
        end
        n_tests++;
        if (seen_l !== (64'd1 << 4) || seen_r !== (64'd1 << 10)) begin
            n_fail++;
            $display("FAIL b2b_cycles left=%h right=%h want_left=%h want_right=%h",
                     seen_l, seen_r, 64'd1 << 4, 64'd1 << 10);
        end
    endtask

    task automatic test_pause();
        int first_right;
        first_right = -1;
        for (int t = 0; t < 80; t++) begin
            pause = (t < 40);
            if ((t >= 2 && t < 50) || (t >= 60 && t < 70)) set_keys(1'b1, 8'h74, 1'b0, 8'hF0);
            else                                           set_keys(1'b0, 8'hF0, 1'b0, 8'hF0);
            tick();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL pause_model t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (mv_right === 1'b1 && first_right < 0) first_right = t;
        end
        n_tests++;
        if (first_right !== 64) begin
            n_fail++;
            $display("FAIL pause_first_right got=%0d want=64", first_right);
        end
        for (int t = 0; t < 14; t++) begin
            pause = 1'b1;
            if (t < 6) set_keys(1'b1, 8'h5A, 1'b1, 8'h6B);
            else       set_keys(1'b0, 8'hF0, 1'b0, 8'hF0);
            tick();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL pause_start_model t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (t == 4) begin
                n_tests++;
                if (obs !== B_START) begin
                    n_fail++;
                    $display("FAIL pause_start t=4 got=%b want=%b", obs, B_START);
                end
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_reset_midhold();
        int held_pulses;
        held_pulses = 0;
        for (int t = 0; t < 56; t++) begin
            rst = (t >= 12 && t < 15);
            if (t < 30 || (t >= 40 && t < 46)) set_keys(1'b1, 8'h6B, 1'b0, 8'hF0);
            else                               set_keys(1'b0, 8'hF0, 1'b0, 8'hF0);
            tick();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rstmid_model t=%0d got=%b want=%b", t, obs, exp_v);
            end
            if (t >= 13 && t < 44 && obs !== 7'b0) held_pulses++;
            if (t == 44) begin
                n_tests++;
                if (mv_left !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rstmid_repress t=44 got=%b want=1", mv_left);
                end
            end
        end
        n_tests++;
        if (held_pulses !== 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet got=%0d want=0", held_pulses);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] codes [10] = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h5A,
                                   8'h12, 8'h22, 8'h1A, 8'h33, 8'hF0};
        logic       h1_on, h2_on;
        logic [7:0] h1_code, h2_code, c;
        h1_on = 1'b0; h1_code = 8'hF0;
        h2_on = 1'b0; h2_code = 8'hF0;
        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 15) == 0) begin
                c = codes[$urandom_range(0, 9)];
                h1_on   = (c != 8'hF0);
                h1_code = c;
            end
            if ($urandom_range(0, 9) == 0) begin
                c = codes[$urandom_range(0, 9)];
                h2_on   = (c != 8'hF0);
                h2_code = c;
            end
            if ($urandom_range(0, 59) == 0) pause = ~pause;
            if ($urandom_range(0, 39) == 0) begin
                // one-cycle torn sample on slot 1
                set_keys(~h1_on, 8'($urandom_range(0, 255)), h2_on, h2_code);
            end else begin
                set_keys(h1_on, h1_code, h2_on, h2_code);
            end
            tick();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random_model t=%0d got=%b want=%b", t, obs, exp_v);
            end
        end
        pause = 1'b0;
        set_keys(1'b0, 8'hF0, 1'b0, 8'hF0);
    endtask

    initial begin
        test_reset();
        test_das_repeat();
        test_single_pulse();
        test_simultaneous();
        test_glitch();
        test_back_to_back();
        test_pause();
        test_reset_midhold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
